// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory response block.
// Holds the memory geometry, the store-buffer entry layout and the lane-merge
// helper used both for forwarding and for array writes.
package dmem_pkg;

    localparam int DMEM_WORDS = 256;
    localparam int SB_DEPTH   = 2;
    localparam int IDX_W      = 8;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [3:0]       be;
        logic [31:0]      data;
    } sb_entry_t;

    // Overlay the enabled byte lanes of a buffered store onto a base word.
    function automatic logic [31:0] mergeLanes(input logic [31:0] base,
                                               input sb_entry_t   e);
        logic [31:0] r;
        r = base;
        for (int unsigned b = 0; b < 4; b++) begin
            if (e.be[b]) begin
                r[8*b +: 8] = e.data[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/store_buf.sv
// Two-entry FIFO store buffer.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   enq, enqEntry  push an entry (ignored when full)
//   deq            pop the head entry (ignored when empty)
//   full, empty    occupancy flags
//   older/newer    entries in age order for forwarding; *Valid marks presence
import dmem_pkg::*;

module store_buf (
    input  logic      clk,
    input  logic      rst,
    input  logic      enq,
    input  sb_entry_t enqEntry,
    input  logic      deq,
    output logic      full,
    output logic      empty,
    output sb_entry_t older,
    output logic      olderValid,
    output sb_entry_t newer,
    output logic      newerValid
);

    sb_entry_t  entries [SB_DEPTH];
    logic       wrPtr;
    logic       rdPtr;
    logic [1:0] count;
    logic       doEnq;
    logic       doDeq;

    assign full  = (count == 2'(SB_DEPTH));
    assign empty = (count == 2'd0);
    assign doEnq = enq && !full;
    assign doDeq = deq && !empty;

    assign older      = entries[rdPtr];
    assign olderValid = !empty;
    assign newer      = entries[~rdPtr];
    assign newerValid = full;

    // Payload storage is not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (doEnq) begin
            entries[wrPtr] <= enqEntry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doEnq) begin
                wrPtr <= ~wrPtr;
            end
            if (doDeq) begin
                rdPtr <= ~rdPtr;
            end
            case ({doEnq, doDeq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory response block: 256 x 32-bit array behind a 2-entry store buffer.
// Writes are posted into the buffer and drained to the array in cycles without
// an accepted request; reads forward buffered bytes over array data.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   en         request valid
//   wen        byte write enables (0 = read)
//   addr       byte address, addr[9:2] selects the word
//   wdata      lane-aligned store data
//   rdata      registered read data (holds when rvalid=0)
//   rvalid     one-cycle read-data pulse
//   stall      write refused because the buffer is full
//   sb_empty   store buffer holds no entries
import dmem_pkg::*;

module dmem_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall,
    output logic        sb_empty
);

    logic [31:0]      mem [DMEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic             isWrite;
    logic             acceptWr;
    logic             acceptRd;
    logic             drain;
    logic             full;
    logic             empty;
    sb_entry_t        enqEntry;
    sb_entry_t        older;
    sb_entry_t        newer;
    logic             olderValid;
    logic             newerValid;
    logic [31:0]      merged;
    logic             unusedAddr;

    assign idx        = addr[9:2];
    assign unusedAddr = ^{addr[31:10], addr[1:0]};
    assign isWrite    = |wen;

    assign stall    = en && isWrite && full;
    assign acceptWr = en && isWrite && !full;
    assign acceptRd = en && !isWrite;
    // The array port is free whenever no request is accepted.
    assign drain    = !empty && (!en || stall);
    assign sb_empty = empty;

    assign enqEntry = '{idx: idx, be: wen, data: wdata};

    store_buf u_store_buf (
        .clk        (clk),
        .rst        (rst),
        .enq        (acceptWr),
        .enqEntry   (enqEntry),
        .deq        (drain),
        .full       (full),
        .empty      (empty),
        .older      (older),
        .olderValid (olderValid),
        .newer      (newer),
        .newerValid (newerValid)
    );

    // Apply older entry first so the newer entry wins on overlapping lanes.
    always_comb begin
        merged = mem[idx];
        if (olderValid && older.idx == idx) begin
            merged = mergeLanes(merged, older);
        end
        if (newerValid && newer.idx == idx) begin
            merged = mergeLanes(merged, newer);
        end
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            mem[older.idx] <= mergeLanes(mem[older.idx], older);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= acceptRd;
            if (acceptRd) begin
                rdata <= merged;
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        sb_empty;

    int checks = 0;
    int errors = 0;

    dmem_resp dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wen      (wen),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .stall    (stall),
        .sb_empty (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle();
        req(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        repeat (2) tick();
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_sb_empty", {31'b0, sb_empty}, 32'd1);
        rst = 1'b1;
        tick();

        // Write, drain on idle, read back from array
        req(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF); tick();
        check("wr_sb_nonempty", {31'b0, sb_empty}, 32'd0);
        idle(); tick();
        check("drain_sb_empty", {31'b0, sb_empty}, 32'd1);
        req(1'b1, 4'b0000, 32'h10, 32'h0); tick();
        check("rd10_rvalid", {31'b0, rvalid}, 32'd1);
        check("rd10_rdata", rdata, 32'hDEADBEEF);
        check("rd10_sb_empty", {31'b0, sb_empty}, 32'd1);
        idle(); tick();
        check("rvalid_pulse", {31'b0, rvalid}, 32'd0);
        check("rdata_hold", rdata, 32'hDEADBEEF);

        // Forwarding from buffer without idle cycle
        req(1'b1, 4'b1111, 32'h20, 32'h11223344); tick();
        req(1'b1, 4'b0000, 32'h20, 32'h0); tick();
        check("fwd20_rvalid", {31'b0, rvalid}, 32'd1);
        check("fwd20_rdata", rdata, 32'h11223344);
        check("fwd20_sb_empty", {31'b0, sb_empty}, 32'd0);
        idle(); tick();

        // Partial lane merge across two buffered entries over the array word
        req(1'b1, 4'b0001, 32'h20, 32'h000000AA); tick();
        req(1'b1, 4'b0100, 32'h20, 32'h00BB0000); tick();
        req(1'b1, 4'b0000, 32'h20, 32'h0); #1;
        check("read_full_nostall", {31'b0, stall}, 32'd0);
        tick();
        check("merge20_fwd", rdata, 32'h11BB33AA);
        idle(); tick(); tick();
        check("merge20_drained", {31'b0, sb_empty}, 32'd1);
        req(1'b1, 4'b0000, 32'h20, 32'h0); tick();
        check("merge20_array", rdata, 32'h11BB33AA);

        // Same lanes in both entries: newest wins
        req(1'b1, 4'b1111, 32'h30, 32'h01020304); tick();
        req(1'b1, 4'b0011, 32'h30, 32'h0000AABB); tick();
        req(1'b1, 4'b0000, 32'h30, 32'h0); tick();
        check("newest_wins", rdata, 32'h0102AABB);
        idle(); tick(); tick();

        // Three back-to-back writes: one stall cycle on the third
        req(1'b1, 4'b1111, 32'h0, 32'hA0A0A0A0); tick();
        req(1'b1, 4'b1111, 32'h4, 32'hB1B1B1B1); #1;
        check("second_wr_nostall", {31'b0, stall}, 32'd0);
        tick();
        req(1'b1, 4'b1111, 32'h8, 32'hC2C2C2C2); #1;
        check("third_wr_stall", {31'b0, stall}, 32'd1);
        tick();
        check("stall_one_cycle", {31'b0, stall}, 32'd0);
        tick();
        idle(); #1;
        check("after_accept_full", {31'b0, sb_empty}, 32'd0);
        tick(); tick(); tick();
        check("three_drained", {31'b0, sb_empty}, 32'd1);
        req(1'b1, 4'b0000, 32'h0, 32'h0); tick();
        check("rd0", rdata, 32'hA0A0A0A0);
        req(1'b1, 4'b0000, 32'h4, 32'h0); tick();
        check("rd4", rdata, 32'hB1B1B1B1);
        req(1'b1, 4'b0000, 32'h8, 32'h0); tick();
        check("rd8", rdata, 32'hC2C2C2C2);

        // Upper address bits ignored
        req(1'b1, 4'b1111, 32'h410, 32'hCAFEF00D); tick();
        idle(); tick();
        req(1'b1, 4'b0000, 32'h010, 32'h0); tick();
        check("alias_410", rdata, 32'hCAFEF00D);

        // Reset discards buffered stores
        req(1'b1, 4'b1111, 32'h40, 32'h0A0A0A0A); tick();
        idle(); tick();
        req(1'b1, 4'b1111, 32'h44, 32'h0B0B0B0B); tick();
        idle(); tick();
        req(1'b1, 4'b1111, 32'h40, 32'h55555555); tick();
        req(1'b1, 4'b1111, 32'h44, 32'h66666666); tick();
        req(1'b1, 4'b0000, 32'h40, 32'h0); tick();
        check("pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
        check("pre_rst_fwd", rdata, 32'h55555555);
        #2;
        rst = 1'b0;
        #1;
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
        req(1'b1, 4'b0000, 32'h40, 32'h0);
        tick(); tick();
        check("no_accept_in_rst", {31'b0, rvalid}, 32'd0);
        rst = 1'b1;
        idle(); tick();
        check("post_rst_sb_empty", {31'b0, sb_empty}, 32'd1);
        req(1'b1, 4'b0000, 32'h40, 32'h0); tick();
        check("post_rst_rd40", rdata, 32'h0A0A0A0A);
        req(1'b1, 4'b0000, 32'h44, 32'h0); tick();
        check("post_rst_rd44", rdata, 32'h0B0B0B0B);
        idle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 en  input  1  core data-port request valid this cycle.
REQ-004 wen  input  4  byte-lane write enables; 4'b0000 with en=1 means read.
REQ-005 addr  input  32  byte address from core; only addr[9:2] used (word index), rest ignored.
REQ-006 wdata  input  32  lane-aligned store data.
REQ-007 rdata  output  32  registered read data.
REQ-008 rvalid  output  1  one-cycle pulse, rdata valid.
REQ-009 stall  output  1  combinational; request not accepted this cycle, core holds request.
REQ-010 sb_empty  output  1  store buffer holds no entries.

Function
REQ-011 Storage SHALL be 256 x 32-bit words, single shared array port (one read or one write per cycle).
REQ-012 Request accepted when en=1 and stall=0; read if wen=0, write otherwise.
REQ-013 Accepted write SHALL enqueue {index, wen, wdata} into a 2-entry FIFO store buffer; no coalescing of same-index entries.
REQ-014 Drain: head entry SHALL be written to the array (only lanes with wen bit set) and dequeued in any cycle where buffer non-empty and (en=0 or stall=1).
REQ-015 stall SHALL equal en and (wen!=0) and buffer full; reads never stall.
REQ-016 Stalled cycle drains head; the held write is accepted the next cycle (stall lasts exactly 1 cycle per full event).
REQ-017 Read latency 1 cycle: rdata/rvalid update on the edge after acceptance; rvalid=0 in all other cycles.
REQ-018 Read data SHALL be array word with each byte lane overridden by buffered entries to the same index, newest entry winning per lane.
REQ-019 Read in same cycle as a write enqueue is impossible (single request); read in a cycle with no drain sees buffer state before that edge.
REQ-020 rdata SHALL hold its last value when rvalid=0.
REQ-021 FIFO pointers SHALL wrap modulo 2; count range 0..2; sb_empty = (count==0).
REQ-022 Back-to-back writes with no idle cycle SHALL fill the buffer; drain resumes only on idle/stall cycles.

Reset
REQ-023 rst low SHALL immediately clear: buffer count and pointers to 0, rvalid=0, rdata=32'h0, sb_empty=1.
REQ-024 Reset mid-operation SHALL discard undrained buffer entries; array contents are not reset and are undefined until written.
REQ-025 No request SHALL be accepted while rst is low; first accept possible on the first edge after release.

Structure
REQ-026 Shared package dmem_pkg SHALL hold DMEM_WORDS=256, SB_DEPTH=2, index width 8, and the store-buffer entry struct {idx[7:0], be[3:0], data[31:0]}.
REQ-027 Store buffer SHALL be a sub-module store_buf (enqueue, dequeue, full/empty, per-entry lookup for forwarding); array, merge and stall logic in dmem_resp.

Verification
REQ-028 Write addr=0x10 wen=1111 wdata=0xDEADBEEF, idle 1 cycle, read 0x10 -> next cycle rvalid=1, rdata=0xDEADBEEF, sb_empty=1.
REQ-029 Write 0x20 wen=1111 0x11223344, immediately read 0x20 (no idle) -> rdata=0x11223344 via forwarding, sb_empty=0.
REQ-030 Array word 0x20=0x11223344, write wen=0001 0x000000AA, then wen=0100 0x00BB0000, read 0x20 -> rdata=0x11BB33AA.
REQ-031 Three consecutive writes (0x0,0x4,0x8) -> stall=1 on third for exactly one cycle, accepted next cycle; after 3 idle cycles all three readable, sb_empty=1.
REQ-032 Two writes buffered, assert rst low mid-cycle -> rvalid=0, rdata=0, sb_empty=1 immediately; later reads of those addresses return pre-existing array data, not buffered data.
REQ-033 Write addr=0x410 wen=1111 0xCAFEF00D, read addr=0x010 -> rdata=0xCAFEF00D (upper address bits ignored).
